// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a small circular FIFO of {instr, pc}
// pairs. The head entry is presented to decode with a valid/ready handshake.
// The full flag doubles as the fetch stall.
module if_id_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic           in_valid,
  input  logic [31:0]    in_instr,
  input  logic [31:0]    in_pc,
  input  logic           flush,
  input  logic           out_ready,
  output logic           full,
  output logic           out_valid,
  output logic [31:0]    out_instr,
  output logic [31:0]    out_pc,
  output logic [31:0]    out_pc4,
  output logic [31:0]    out_pc8,
  output logic [PTR_W:0] count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t         mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   cnt_q;
  logic             push, pop;
  entry_t           head;

  // Status comes only from the registered count, so full/out_valid have
  // no combinational path from in_valid or out_ready.
  assign full      = (cnt_q == FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign count     = cnt_q;

  // An empty queue never pops, so a fresh entry surfaces one cycle later.
  assign push = in_valid & ~full;
  assign pop  = out_valid & out_ready;

  // Pointer and occupancy state; reset beats flush beats normal traffic.
  always_ff @(posedge clk) begin
    if (Reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt_q <= cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Entry storage; a push in a flush or reset cycle is wrong-path and dropped.
  always_ff @(posedge clk) begin
    if (push && !flush && !Reset) begin
      mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
    end
  end

  // Head read, masked to a nop at RESET_PC when nothing is queued.
  always_comb begin
    head      = mem[rd_ptr];
    out_instr = 32'h0;
    out_pc    = RESET_PC;
    if (out_valid) begin
      out_instr = head.instr;
      out_pc    = head.pc;
    end
  end

  assign out_pc4 = out_pc + 32'd4;
  assign out_pc8 = out_pc + 32'd8;

  // Occupancy can never exceed the array size.
  a_cnt_bound: assert property (@(posedge clk) disable iff (Reset) cnt_q <= FULL_CNT);

endmodule

// File: tb/tb_if_id_queue.sv
// Directed, table-driven bench for the fetch-to-decode queue.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        Reset, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        full, out_valid;
  logic [31:0] out_instr, out_pc, out_pc4, out_pc8;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_ready(out_ready), .full(full),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc4(out_pc4), .out_pc8(out_pc8), .count(count)
  );

  typedef struct {
    string       name;
    logic        rst, iv, fl, rdy;
    logic [31:0] instr, pc;
    logic [2:0]  e_cnt;
    logic        e_vld, e_full;
    logic [31:0] e_instr, e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Add one vector: inputs applied at the next edge, outputs expected after it.
  task automatic add(input string n, input logic rst, input logic iv, input logic fl,
                     input logic rdy, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [2:0] ec, input logic ev, input logic ef,
                     input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.name = n; v.rst = rst; v.iv = iv; v.fl = fl; v.rdy = rdy;
    v.instr = ins; v.pc = pc; v.e_cnt = ec; v.e_vld = ev; v.e_full = ef;
    v.e_instr = ei; v.e_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic add_empty(input string n, input logic rst, input logic iv,
                           input logic fl, input logic rdy, input logic [31:0] pc);
    add(n, rst, iv, fl, rdy, 32'hDEAD_0000 | pc, pc, 3'd0, 1'b0, 1'b0, 32'h0, 32'h3000);
  endtask

  task automatic check_outputs(input string n, input logic [2:0] ec, input logic ev,
                               input logic ef, input logic [31:0] ei, input logic [31:0] ep);
    chk({n, ".count"}, 32'(count), 32'(ec));
    chk({n, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({n, ".full"}, 32'(full), 32'(ef));
    chk({n, ".out_instr"}, out_instr, ei);
    chk({n, ".out_pc"}, out_pc, ep);
    chk({n, ".out_pc4"}, out_pc4, ep + 32'd4);
    chk({n, ".out_pc8"}, out_pc8, ep + 32'd8);
  endtask

  initial begin
    Reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;

    // Reset and idle.
    add_empty("reset", 1, 0, 0, 0, 32'h0);
    add_empty("idle",  0, 0, 0, 0, 32'h0);
    // Fill with decode stalled; the fifth offer is dropped.
    add("fill1", 0, 1, 0, 0, 32'h2401_0001, 32'h3000, 3'd1, 1, 0, 32'h2401_0001, 32'h3000);
    add("fill2", 0, 1, 0, 0, 32'h2401_0002, 32'h3004, 3'd2, 1, 0, 32'h2401_0001, 32'h3000);
    add("fill3", 0, 1, 0, 0, 32'h2401_0003, 32'h3008, 3'd3, 1, 0, 32'h2401_0001, 32'h3000);
    add("fill4", 0, 1, 0, 0, 32'h2401_0004, 32'h300C, 3'd4, 1, 1, 32'h2401_0001, 32'h3000);
    add("drop5", 0, 1, 0, 0, 32'h2401_0005, 32'h3010, 3'd4, 1, 1, 32'h2401_0001, 32'h3000);
    // Drain in order.
    add("pop1", 0, 0, 0, 1, 32'h0, 32'h0, 3'd3, 1, 0, 32'h2401_0002, 32'h3004);
    add("pop2", 0, 0, 0, 1, 32'h0, 32'h0, 3'd2, 1, 0, 32'h2401_0003, 32'h3008);
    add("pop3", 0, 0, 0, 1, 32'h0, 32'h0, 3'd1, 1, 0, 32'h2401_0004, 32'h300C);
    add_empty("pop4", 0, 0, 0, 1, 32'h0);
    // Streaming push+pop; pointers wrap three times.
    for (int k = 0; k < 12; k++)
      add($sformatf("strm%0d", k), 0, 1, 0, 1, 32'h2402_0000 + k, 32'h3000 + 4*k,
          3'd1, 1, 0, 32'h2402_0000 + k, 32'h3000 + 4*k);
    add_empty("strm_end", 0, 0, 0, 1, 32'h0);
    // Flush with a concurrent push.
    add("fq1", 0, 1, 0, 0, 32'h2403_0001, 32'h3020, 3'd1, 1, 0, 32'h2403_0001, 32'h3020);
    add("fq2", 0, 1, 0, 0, 32'h2403_0002, 32'h3024, 3'd2, 1, 0, 32'h2403_0001, 32'h3020);
    add("fq3", 0, 1, 0, 0, 32'h2403_0003, 32'h3028, 3'd3, 1, 0, 32'h2403_0001, 32'h3020);
    add_empty("flush", 0, 1, 1, 1, 32'h3040);
    add("after_fl", 0, 1, 0, 0, 32'h2404_0000, 32'h3080, 3'd1, 1, 0, 32'h2404_0000, 32'h3080);
    add("f2", 0, 1, 0, 0, 32'h2404_0001, 32'h3084, 3'd2, 1, 0, 32'h2404_0000, 32'h3080);
    add("f3", 0, 1, 0, 0, 32'h2404_0002, 32'h3088, 3'd3, 1, 0, 32'h2404_0000, 32'h3080);
    add("f4", 0, 1, 0, 0, 32'h2404_0003, 32'h308C, 3'd4, 1, 1, 32'h2404_0000, 32'h3080);
    // Full: push blocked, pop still taken.
    add("full_pop", 0, 1, 0, 1, 32'h2405_0000, 32'h30F0, 3'd3, 1, 0, 32'h2404_0001, 32'h3084);
    add("refill", 0, 1, 0, 0, 32'h2405_0000, 32'h30F0, 3'd4, 1, 1, 32'h2404_0001, 32'h3084);
    // Reset while full with decode ready.
    add_empty("rst_full", 1, 1, 0, 1, 32'h3100);
    add_empty("rst_idle", 0, 0, 0, 1, 32'h0);

    foreach (vecs[i]) begin
      Reset = vecs[i].rst; in_valid = vecs[i].iv; flush = vecs[i].fl;
      out_ready = vecs[i].rdy; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
      @(posedge clk); #1;
      check_outputs(vecs[i].name, vecs[i].e_cnt, vecs[i].e_vld, vecs[i].e_full,
                    vecs[i].e_instr, vecs[i].e_pc);
    end

    // Hand sequence: empty queue ignores out_ready, and status has no
    // combinational path from the handshake inputs.
    Reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_outputs($sformatf("rdy_empty%0d", c), 3'd0, 0, 0, 32'h0, 32'h3000);
    end
    in_valid = 1'b1; in_pc = 32'h3200; in_instr = 32'h2406_0000; out_ready = 1'b1;
    #1;
    chk("comb_valid", 32'(out_valid), 32'd0);
    chk("comb_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check_outputs("lat1", 3'd1, 1, 0, 32'h2406_0000, 32'h3200);
    // Flush and reset together: empty next cycle.
    Reset = 1'b1; flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_outputs("rst_flush", 3'd0, 0, 0, 32'h0, 32'h3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Captures each fetched {instruction, PC} pair into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Its full flag drives the fetch unit's stall_pc input.
- A redirect flush (taken jump/branch) discards all queued wrong-path instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, 2, pointer width; log2(DEPTH).
- RESET_PC, 32'h00003000, value reported on out_pc when the queue is empty.

Ports:
- clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch presents a valid instruction this cycle
- in_instr  input  32  fetched instruction word
- in_pc  input  32  address of in_instr
- flush  input  1  redirect; discard all entries and this cycle's push
- out_ready  input  1  decode accepts the head entry this cycle (low = decode stall)
- full  output  1  count == DEPTH; connects to fetch stall_pc
- out_valid  output  1  head entry is valid
- out_instr  output  32  head instruction; 32'h0 (nop) when empty
- out_pc  output  32  head PC; RESET_PC when empty
- out_pc4  output  32  out_pc + 4
- out_pc8  output  32  out_pc + 8
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH

Behaviour:
- Clock and reset: single clock clk; Reset is synchronous and active-high.
- Storage:
  - DEPTH x 64-bit array holding {instr, pc}.
  - Registers: rd_ptr and wr_ptr (PTR_W bits), count (PTR_W+1 bits).
  - Pointers wrap modulo DEPTH with natural overflow.
- Reset, sampled at posedge clk:
  - rd_ptr, wr_ptr and count go to 0.
  - Outputs become out_valid=0, full=0, out_instr=0, out_pc=RESET_PC, out_pc4=RESET_PC+4, out_pc8=RESET_PC+8.
  - Array contents need not be cleared.
- Events per cycle:
  - push = in_valid & ~full
  - pop = out_valid & out_ready
  - full and out_valid are decoded from the registered count, so they have no combinational path from in_valid or out_ready.
- Priority each posedge: Reset > flush > normal operation.
  - flush=1: rd_ptr, wr_ptr and count go to 0. Any push and pop in that cycle are discarded. The array is unchanged.
  - Normal operation:
    - push writes array[wr_ptr] and advances wr_ptr by 1.
    - pop advances rd_ptr by 1.
    - count += push - pop; simultaneous push and pop leaves count unchanged.
- Full queue: push is blocked (in_valid ignored), but pop is still allowed. After a pop, full drops the next cycle.
- Empty queue:
  - out_valid=0, out_instr=0 and out_pc=RESET_PC, so decode sees a nop bubble.
  - out_ready is ignored.
  - Push and pop in the same cycle cannot occur; an entry pushed into an empty queue appears on the outputs in the following cycle, giving a latency of 1.
- Output path:
  - out_instr and out_pc are combinational reads of array[rd_ptr], gated by out_valid.
  - out_pc4 and out_pc8 use 32-bit modulo addition.
- Reset or flush mid-stream: the next cycle always shows the empty state, regardless of in_valid or out_ready.
- Throughput: one push and one pop per cycle sustained when DEPTH>=2 and the queue is neither empty nor full.

Test Plan:
- Reset then idle: assert Reset one cycle -> count=0, out_valid=0, full=0, out_instr=0, out_pc=32'h3000, out_pc4=32'h3004, out_pc8=32'h3008.
- Fill with decode stalled: out_ready=0; push pc 3000,3004,3008,300C with instr 0x24010001..0x24010004 -> count 1,2,3,4, full=1 after the 4th push. A 5th in_valid (pc 3010) is dropped; count stays 4.
- Drain in order: from the full state set in_valid=0, out_ready=1 -> out_pc sequence 3000,3004,3008,300C with matching instrs. full=0 after the first pop; out_valid=0 after the 4th; count reaches 0.
- Simultaneous push and pop with wrap-around: stream 12 instructions with in_valid=1 and out_ready=1 -> count stays at 1 and outputs are in order. Pointers wrap 3 times with no loss or duplication (out_pc = 3000+4k).
- Flush with a concurrent push: queue holds 3 entries, pulse flush with in_valid=1, in_pc=3040 -> next cycle count=0, out_valid=0. The 3040 entry is absent, and a following push of pc 3080 appears as head.
- Reset while full and out_ready=1 -> next cycle empty state identical to the post-reset case; no pop of the old head is observed.
